fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences instruction-memory requests for the front end. Issues one aligned 32-bit fetch at a time over a valid/ready request port, accepts the response, and presents {pc, instruction} to decode through a one-entry valid/ready output stage. Applies branch/jump redirects from execute, discards in-flight responses made stale by a redirect, supports halt, and flags misaligned redirect targets.

## Interface
- `XLEN`, default 32: address and instruction width.
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in XLEN: redirect target.
- `halt` in 1: level; while high, no new fetch requests are issued.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out XLEN: fetch address, word aligned.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_resp_valid` in 1: response strobe, one cycle, not backpressurable.
- `imem_resp_data` in XLEN: instruction word.
- `if_valid` out 1: output entry valid.
- `if_pc` out XLEN: PC of the output instruction.
- `if_instr` out XLEN: output instruction.
- `if_ready` in 1: decode accepts the output entry.
- `misalign_fault` out 1: sticky; redirect target had `[1:0] != 0`.

## Operation
- FSM states: IDLE, REQ, WAIT, FAULT.
- IDLE: entered on reset. Moves to REQ when `halt`=0 and the output entry is free (`if_valid`=0).
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. Address held stable until `imem_req_ready`. Handshake moves to WAIT.
- WAIT: on `imem_resp_valid`:
  - discard flag set: drop the response, clear the flag, go to IDLE.
  - discard flag clear: load `if_pc`=pc, `if_instr`=data, `if_valid`=1, pc<=pc+4 (mod 2^XLEN, wraps), go to IDLE.
- Output stage: `if_valid` clears on `if_valid && if_ready`. A new request is issued only when the entry is free, so responses can never overrun it.
- Redirect (aligned target), highest priority:
  - pc<=redirect_pc.
  - `if_valid`<=0. A transfer in the same cycle still completes; decode kills it itself.
  - WAIT, or REQ with handshake this cycle: set the discard flag.
  - REQ without handshake: the request stays pending, unchanged; set the discard flag.
  - WAIT with `imem_resp_valid` in the same cycle: the response is dropped, next state IDLE.
- Misaligned redirect: pc unchanged, `misalign_fault`<=1, `if_valid`<=0.
  - From REQ/WAIT, the outstanding request completes and its response is discarded; then FAULT.
  - FAULT issues nothing. Only reset leaves it.
- Halt: blocks the IDLE to REQ transition only. Outstanding requests complete normally.
- `imem_resp_valid` outside WAIT: protocol violation, ignored.

## Timing
- Reset values: pc=RESET_PC, state IDLE, discard=0, `imem_req_valid`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `misalign_fault`=0.
- First `imem_req_valid` is in the cycle after `reset` is first sampled low.
- Best case, with ready=1 and 1-cycle response latency:
  - request at cycle N, response at N+1, `if_valid` at N+2.
  - next request at N+3 if the entry was consumed at N+2.
- Redirect sampled at edge E: if idle, a request to the new pc appears at E+1.
- Reset mid-operation discards everything; a late response after reset is ignored.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (F_IDLE, F_REQ, F_WAIT, F_FAULT), `PC_STEP`=4, alignment-check function.
- Sub-module `fetch_pc_gen`: pc register, next-pc mux (hold / +4 / redirect) and misalign detect. The FSM, discard flag and output stage stay in `fetch_ctrl`.

## Test plan
- Reset, then ready=1, 1-cycle response with data=addr^32'hA5A5_0000 and if_ready=1 -> request addresses 0,4,8; `if_pc`=0 and `if_instr`=32'hA5A5_0000 at cycle 3.
- Hold `if_ready`=0 after the first fetch -> `imem_req_valid` stays 0; `if_pc`=0 and `if_instr` stable; release -> next request to 4.
- Redirect to 32'h100 while in WAIT for addr 8 -> response for 8 is never presented; next request address is 32'h100.
- Redirect to 32'h102 -> `misalign_fault`=1, no further requests, `if_valid`=0 until reset.
- Redirect to 32'h40 with req_ready=0 in REQ -> pending request to addr stays stable until accepted; its response is dropped; next request is 32'h40.
- Assert `halt` during WAIT -> response delivered, no new request; deassert -> request to pc+4. Reset asserted mid-WAIT -> late response ignored, first request to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the instruction-fetch controller.
//               FSM state encoding, PC increment step and the word-alignment
//               check used on redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_REQ   = 2'd1,
        F_WAIT  = 2'd2,
        F_FAULT = 2'd3
    } fetch_state_t;

    localparam int PC_STEP = 4;

    // A fetch target is usable only when it is 32-bit word aligned.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bus bundle between the fetch controller, instruction memory
//               and decode.
//   imem_req_valid/addr/ready : fetch request handshake
//   imem_resp_valid/data      : one-cycle, non-backpressurable response
//   if_valid/pc/instr/ready   : one-entry output stage towards decode
//   master modport = fetch controller, slave modport = memory + decode side
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Program counter register with hold / +4 / redirect next-pc
//               selection and misaligned-redirect detection.
//   clk, reset      : clock, synchronous active-high reset (pc <= RESET_PC)
//   redirect_valid  : execute requests a PC change
//   redirect_pc     : redirect target
//   advance         : an instruction was accepted; step pc by PC_STEP
//   pc              : current program counter
//   redirect_ok     : aligned redirect this cycle (pc takes redirect_pc)
//   redirect_bad    : misaligned redirect this cycle (pc held)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    input  wire logic            advance,
    output logic      [XLEN-1:0] pc,
    output logic                 redirect_ok,
    output logic                 redirect_bad
);

    logic [XLEN-1:0] r_pc;
    logic            w_aligned;

    assign w_aligned    = is_aligned(redirect_pc[1:0]);
    assign redirect_ok  = redirect_valid &&  w_aligned;
    assign redirect_bad = redirect_valid && !w_aligned;
    assign pc           = r_pc;

    // Redirect wins over sequential advance; the increment wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_ok) begin
            r_pc <= redirect_pc;
        end else if (advance && !redirect_valid) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller. Issues one aligned fetch at a
//               time, captures the response into a one-entry output stage,
//               applies redirects (discarding stale responses), honours halt
//               and latches a sticky fault on misaligned redirect targets.
//   clk, reset     : clock, synchronous active-high reset
//   redirect_valid : execute requests a PC change this cycle
//   redirect_pc    : redirect target
//   halt           : level; blocks issuing new fetch requests
//   misalign_fault : sticky; a redirect target was not word aligned
//   bus            : fetch_ctrl_if master (imem request/response, decode out)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    input  wire logic            halt,
    output logic                 misalign_fault,
    fetch_ctrl_if.master         bus
);

    fetch_state_t    r_state;
    logic            r_discard;
    logic            r_fault;
    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;

    logic [XLEN-1:0] w_pc;
    logic            w_redir_ok;
    logic            w_redir_bad;
    logic            w_accept;
    logic            w_entry_free;
    logic [XLEN-1:0] w_fetch_pc;

    // A response is kept only if it is not stale and no redirect lands with it.
    assign w_accept = (r_state == F_WAIT) && bus.imem_resp_valid &&
                      !r_discard && !redirect_valid;

    // The entry counts as free when it will be empty after this edge; a
    // redirect always empties it.
    assign w_entry_free = !r_if_valid || bus.if_ready || w_redir_ok;

    // An aligned redirect sampled in IDLE is fetched immediately.
    assign w_fetch_pc = w_redir_ok ? redirect_pc : w_pc;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (w_accept),
        .pc             (w_pc),
        .redirect_ok    (w_redir_ok),
        .redirect_bad   (w_redir_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= F_IDLE;
            r_discard   <= 1'b0;
            r_fault     <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_if_instr  <= '0;
        end else begin
            if (r_if_valid && bus.if_ready) begin
                r_if_valid <= 1'b0;
            end
            // Any redirect flushes the entry; decode kills a same-cycle transfer.
            if (redirect_valid) begin
                r_if_valid <= 1'b0;
            end
            if (w_redir_bad) begin
                r_fault <= 1'b1;
            end

            case (r_state)
                F_IDLE: begin
                    if (w_redir_bad) begin
                        r_state <= F_FAULT;
                    end else if (!halt && w_entry_free) begin
                        r_state     <= F_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= w_fetch_pc;
                    end
                end
                F_REQ: begin
                    // The pending request keeps its old address; its response
                    // is marked stale instead.
                    if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.imem_req_ready) begin
                        r_state     <= F_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                F_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        r_discard <= 1'b0;
                        if (w_accept) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_req_addr;
                            r_if_instr <= bus.imem_resp_data;
                        end
                        r_state <= (r_fault || w_redir_bad) ? F_FAULT : F_IDLE;
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                F_FAULT: begin
                    r_req_valid <= 1'b0;
                end
                default: begin
                    r_state <= F_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_req_addr;
    assign bus.if_valid       = r_if_valid;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_instr       = r_if_instr;
    assign misalign_fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. A small memory
//               model answers accepted requests after a programmable latency
//               with data = addr ^ 32'hA5A5_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_fault;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misalign_fault (misalign_fault),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake before the edge, then update
    // the memory model 1 time unit after the edge.
    task automatic tick();
        logic        hs;
        logic [31:0] la;
        hs = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
        la = bus.imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            pend_addr = la;
            pend_cnt  = lat;
        end
        bus.imem_resp_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = pend_addr ^ C_KEY;
            end
        end
    endtask

    initial begin
        int n_req;
        reset               = 1'b1;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        halt                = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.if_ready        = 1'b1;

        // Reset values
        tick(); tick();
        check_eq("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check_eq("rst_if_valid",  {31'b0, bus.if_valid}, 32'd0);
        check_eq("rst_if_pc",     bus.if_pc, 32'h0);
        check_eq("rst_if_instr",  bus.if_instr, 32'h0);
        check_eq("rst_fault",     {31'b0, misalign_fault}, 32'd0);

        // Back-to-back sequential fetch, 1-cycle memory
        reset = 1'b0;
        tick();
        check_eq("seq_req0_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check_eq("seq_req0_addr",  bus.imem_req_addr, 32'h0);
        tick(); tick();
        check_eq("seq_out0_valid", {31'b0, bus.if_valid}, 32'd1);
        check_eq("seq_out0_pc",    bus.if_pc, 32'h0);
        check_eq("seq_out0_instr", bus.if_instr, 32'hA5A5_0000);
        tick();
        check_eq("seq_req1_addr",  bus.imem_req_addr, 32'h4);
        check_eq("seq_req1_ifv",   {31'b0, bus.if_valid}, 32'd0);
        tick(); tick();
        check_eq("seq_out1_instr", bus.if_instr, 32'hA5A5_0004);
        tick();
        check_eq("seq_req2_addr",  bus.imem_req_addr, 32'h8);

        // Redirect while waiting on addr 8 (2-cycle memory): response dropped
        lat = 2;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_eq("rdw_ifv_a", {31'b0, bus.if_valid}, 32'd0);
        lat = 1;
        tick();
        check_eq("rdw_ifv_b", {31'b0, bus.if_valid}, 32'd0);
        tick();
        check_eq("rdw_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check_eq("rdw_req_addr",  bus.imem_req_addr, 32'h100);
        tick(); tick();
        check_eq("rdw_out_pc",    bus.if_pc, 32'h100);
        check_eq("rdw_out_instr", bus.if_instr, 32'hA5A5_0100);

        // Decode stalls: no new request, entry held stable
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
            check_eq("stall_if_pc",     bus.if_pc, 32'h100);
            check_eq("stall_if_valid",  {31'b0, bus.if_valid}, 32'd1);
        end
        bus.if_ready = 1'b1;
        tick();
        check_eq("stall_rel_addr", bus.imem_req_addr, 32'h104);

        // Redirect while request is not accepted: address held, response dropped
        bus.imem_req_ready = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check_eq("rdq_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check_eq("rdq_req_addr_a", bus.imem_req_addr, 32'h104);
        tick();
        check_eq("rdq_req_addr_b", bus.imem_req_addr, 32'h104);
        bus.imem_req_ready = 1'b1;
        tick(); tick();
        check_eq("rdq_drop_ifv", {31'b0, bus.if_valid}, 32'd0);
        tick();
        check_eq("rdq_new_addr", bus.imem_req_addr, 32'h40);
        tick(); tick();
        check_eq("rdq_out_pc",    bus.if_pc, 32'h40);
        check_eq("rdq_out_instr", bus.if_instr, 32'hA5A5_0040);

        // Halt during WAIT: response still delivered, then no new request
        tick();
        check_eq("halt_req_addr", bus.imem_req_addr, 32'h44);
        tick();
        halt = 1'b1;
        tick();
        check_eq("halt_out_pc",    bus.if_pc, 32'h44);
        check_eq("halt_out_instr", bus.if_instr, 32'hA5A5_0044);
        n_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.imem_req_valid === 1'b1) n_req++;
        end
        check_eq("halt_no_req", n_req, 32'd0);
        halt = 1'b0;
        tick();
        check_eq("halt_rel_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check_eq("halt_rel_addr",  bus.imem_req_addr, 32'h48);

        // Reset mid-WAIT with a slow memory: late response must be ignored
        lat = 3;
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("mrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check_eq("mrst_if_valid",  {31'b0, bus.if_valid}, 32'd0);
        reset = 1'b0;
        lat   = 1;
        tick();
        check_eq("mrst_req_addr", bus.imem_req_addr, 32'h0);
        check_eq("mrst_late_ifv", {31'b0, bus.if_valid}, 32'd0);
        tick(); tick();
        check_eq("mrst_out_pc",    bus.if_pc, 32'h0);
        check_eq("mrst_out_instr", bus.if_instr, 32'hA5A5_0000);

        // Misaligned redirect during an accepted request: sticky fault, silence
        tick();
        check_eq("mis_req_addr", bus.imem_req_addr, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check_eq("mis_fault", {31'b0, misalign_fault}, 32'd1);
        tick();
        check_eq("mis_drop_ifv", {31'b0, bus.if_valid}, 32'd0);
        n_req = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.imem_req_valid === 1'b1 || bus.if_valid === 1'b1) n_req++;
        end
        check_eq("mis_silent", n_req, 32'd0);
        check_eq("mis_sticky", {31'b0, misalign_fault}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
